// File: rtl/discus_pkg.sv
// Shared definitions for the discus stack processor: opcodes, literal decode
// and the snoop debug-select codes.
package discus_pkg;

    localparam logic [7:0] OP_NOP   = 8'h80;
    localparam logic [7:0] OP_DROP  = 8'h84;
    localparam logic [7:0] OP_DUP   = 8'h88;
    localparam logic [7:0] OP_FETCH = 8'h8C;
    localparam logic [7:0] OP_SWAP  = 8'h90;
    localparam logic [7:0] OP_ADDM  = 8'h94;
    localparam logic [7:0] OP_SUBM  = 8'h98;
    localparam logic [7:0] OP_XORM  = 8'h9C;
    localparam logic [7:0] OP_ADD   = 8'hA0;
    localparam logic [7:0] OP_STORE = 8'hA4;
    localparam logic [7:0] OP_HALT  = 8'hA8;
    localparam logic [7:0] OP_JMP   = 8'hAC;
    localparam logic [7:0] OP_JZ    = 8'hB0;

    typedef enum logic [1:0] {
        DBG_PC     = 2'd0,
        DBG_TOS    = 2'd1,
        DBG_NOS    = 2'd2,
        DBG_STATUS = 2'd3
    } dbg_sel_e;

    // Both literal ranges push the instruction byte unchanged: 0x00-0x7F is the
    // zero-extended 7-bit form, 0xE0-0xFF the sign-extended 5-bit form.
    function automatic logic is_literal(input logic [7:0] b);
        return !b[7] || (b[7:5] == 3'b111);
    endfunction

endpackage

// File: rtl/discus_mem.sv
// 256x8 memory with combinational fetch/data reads, one write port and a
// registered snoop read that can alternatively capture CPU debug state.
module discus_mem (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] fetch_addr,
    output logic [7:0] fetch_data,
    input  logic [7:0] data_addr,
    output logic [7:0] data_rdata,
    input  logic       we,
    input  logic [7:0] waddr,
    input  logic [7:0] wdata,
    input  logic [7:0] snoop_addr,
    input  logic       snoop_mode,
    input  logic [7:0] dbg_data,
    output logic [7:0] snoop_q
);

    logic [7:0] mem [256];

    assign fetch_data = mem[fetch_addr];
    assign data_rdata = mem[data_addr];

    // NOTE: the array is deliberately not reset, so it maps onto plain RAM and
    // program bytes written through the snoop port during reset survive.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Reads the pre-edge contents, so a write at edge k shows up from edge k+1.
    always_ff @(posedge clk) begin
        if (reset) begin
            snoop_q <= 8'h00;
        end else begin
            snoop_q <= snoop_mode ? dbg_data : mem[snoop_addr];
        end
    end

endmodule

// File: rtl/discus_cpu.sv
// discus_cpu: single-cycle 8-bit stack processor with an 8-entry wrapping
// stack; the snoop port loads programs and reads memory or core state.
module discus_cpu
    import discus_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       snoop_clk,
    input  logic [7:0] snoopa,
    input  logic [7:0] snoopd,
    output logic [7:0] snoopq,
    input  logic       snoopm,
    input  logic       snoopp
);

    logic [7:0]      pc, pc_nxt;
    logic [2:0]      sp, sp_nxt, sp_up, sp_dn, sp_dn2;
    logic [7:0][7:0] stk, stk_nxt;
    logic            halted, halt_nxt;
    logic [7:0]      instr, tos, nos, mem_rdata, dbg_data;
    logic            run, cpu_store, mem_we;
    logic            unused_snoop_clk;

    // The snoop port is tied to clk by the integrator; everything runs on clk.
    assign unused_snoop_clk = snoop_clk;

    assign sp_up  = sp + 3'd1;
    assign sp_dn  = sp - 3'd1;
    assign sp_dn2 = sp - 3'd2;
    assign tos    = stk[sp];
    assign nos    = stk[sp_dn];
    assign run    = !snoopp && !halted;
    assign mem_we = snoopp || (run && cpu_store && !reset);

    // NOTE: every signal driven here gets a default first, so no latch is inferred.
    always_comb begin
        pc_nxt    = pc + 8'd1;
        sp_nxt    = sp;
        stk_nxt   = stk;
        halt_nxt  = halted;
        cpu_store = 1'b0;
        if (is_literal(instr)) begin
            sp_nxt         = sp_up;
            stk_nxt[sp_up] = instr;
        end else begin
            case (instr)
                OP_NOP:   ;
                OP_DROP:  sp_nxt = sp_dn;
                OP_DUP: begin
                    stk_nxt[sp_up] = tos;
                    sp_nxt         = sp_up;
                end
                OP_FETCH: stk_nxt[sp] = mem_rdata;
                OP_SWAP: begin
                    stk_nxt[sp]    = nos;
                    stk_nxt[sp_dn] = tos;
                end
                OP_ADDM: begin
                    stk_nxt[sp_dn] = nos + mem_rdata;
                    sp_nxt         = sp_dn;
                end
                OP_SUBM: begin
                    stk_nxt[sp_dn] = nos - mem_rdata;
                    sp_nxt         = sp_dn;
                end
                OP_XORM: begin
                    stk_nxt[sp_dn] = nos ^ mem_rdata;
                    sp_nxt         = sp_dn;
                end
                OP_ADD: begin
                    stk_nxt[sp_dn] = nos + tos;
                    sp_nxt         = sp_dn;
                end
                OP_STORE: begin
                    cpu_store = 1'b1;
                    sp_nxt    = sp_dn2;
                end
                OP_HALT:  halt_nxt = 1'b1;
                OP_JMP: begin
                    pc_nxt = tos;
                    sp_nxt = sp_dn;
                end
                OP_JZ: begin
                    if (nos == 8'h00) begin
                        pc_nxt = tos;
                    end
                    sp_nxt = sp_dn2;
                end
                default:  ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc     <= 8'h00;
            sp     <= 3'd0;
            stk    <= '0;
            halted <= 1'b0;
        end else if (run) begin
            pc     <= pc_nxt;
            sp     <= sp_nxt;
            stk    <= stk_nxt;
            halted <= halt_nxt;
        end
    end

    always_comb begin
        dbg_data = 8'h00;
        case (dbg_sel_e'(snoopa[1:0]))
            DBG_PC:     dbg_data = pc;
            DBG_TOS:    dbg_data = tos;
            DBG_NOS:    dbg_data = nos;
            DBG_STATUS: dbg_data = {halted, 4'b0000, sp};
            default:    ;
        endcase
    end

    // Stores go to the address in TOS with the value in NOS.
    discus_mem u_mem (
        .clk        (clk),
        .reset      (reset),
        .fetch_addr (pc),
        .fetch_data (instr),
        .data_addr  (tos),
        .data_rdata (mem_rdata),
        .we         (mem_we),
        .waddr      (snoopp ? snoopa : tos),
        .wdata      (snoopp ? snoopd : nos),
        .snoop_addr (snoopa),
        .snoop_mode (snoopm),
        .dbg_data   (dbg_data),
        .snoop_q    (snoopq)
    );

endmodule

// File: tb/tb_discus_cpu.sv
// Self-checking bench for discus_cpu: directed programs plus randomized
// lockstep runs against an instruction-level model of the processor.
module tb_discus_cpu;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       snoopm = 1'b0;
    logic       snoopp = 1'b0;
    logic [7:0] snoopa = 8'h00;
    logic [7:0] snoopd = 8'h00;
    logic [7:0] snoopq;

    int checks = 0;
    int errors = 0;

    // Instruction-level model state.
    byte unsigned m_mem [256];
    byte unsigned m_stk [8];
    int           m_sp;
    int           m_pc;
    bit           m_halted;

    discus_cpu dut (
        .clk       (clk),
        .reset     (reset),
        .snoop_clk (clk),
        .snoopa    (snoopa),
        .snoopd    (snoopd),
        .snoopq    (snoopq),
        .snoopm    (snoopm),
        .snoopp    (snoopp)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no finish, required finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic push(input int v);
        m_sp = (m_sp + 1) % 8;
        m_stk[m_sp] = 8'(v & 255);
    endtask

    task automatic pop(output int v);
        v = m_stk[m_sp];
        m_sp = (m_sp + 7) % 8;
    endtask

    task automatic model_reset();
        m_pc = 0;
        m_sp = 0;
        m_halted = 1'b0;
        for (int i = 0; i < 8; i++) m_stk[i] = 8'h00;
    endtask

    task automatic model_exec();
        int op, t, n;
        op = m_mem[m_pc];
        m_pc = (m_pc + 1) % 256;
        if (op < 'h80 || op >= 'hE0) begin
            push(op);
            return;
        end
        case (op)
            'h84: pop(t);
            'h88: begin pop(t); push(t); push(t); end
            'h8C: begin pop(t); push(m_mem[t]); end
            'h90: begin pop(t); pop(n); push(t); push(n); end
            'h94: begin pop(t); pop(n); push(n + m_mem[t]); end
            'h98: begin pop(t); pop(n); push(n - m_mem[t]); end
            'h9C: begin pop(t); pop(n); push(n ^ m_mem[t]); end
            'hA0: begin pop(t); pop(n); push(n + t); end
            'hA4: begin pop(t); pop(n); m_mem[t] = 8'(n); end
            'hA8: m_halted = 1'b1;
            'hAC: begin pop(t); m_pc = t; end
            'hB0: begin pop(t); pop(n); if (n == 0) m_pc = t; end
            default: ;
        endcase
    endtask

    function automatic logic [7:0] dbg_value(input int sel);
        case (sel)
            0:       return 8'(m_pc);
            1:       return m_stk[m_sp];
            2:       return m_stk[(m_sp + 7) % 8];
            default: return 8'((m_halted ? 128 : 0) + m_sp);
        endcase
    endfunction

    // One clock edge with the currently driven inputs; the model follows along
    // and exp_q is what snoopq must show after this edge.
    task automatic step(output logic [7:0] exp_q);
        if (reset)       exp_q = 8'h00;
        else if (snoopm) exp_q = dbg_value(int'(snoopa[1:0]));
        else             exp_q = m_mem[snoopa];
        @(posedge clk);
        #1;
        if (snoopp) m_mem[snoopa] = snoopd;
        if (reset) model_reset();
        else if (!snoopp && !m_halted) model_exec();
    endtask

    task automatic run(input int n);
        logic [7:0] e;
        snoopp = 1'b0;
        repeat (n) step(e);
    endtask

    // Fills all 256 bytes under reset, then leaves the core released.
    task automatic load_program(input byte unsigned prog[$]);
        logic [7:0] e;
        reset  = 1'b1;
        snoopp = 1'b1;
        snoopm = 1'b0;
        for (int a = 0; a < 256; a++) begin
            snoopa = 8'(a);
            snoopd = (a < prog.size()) ? prog[a] : 8'h00;
            step(e);
        end
        reset  = 1'b0;
        snoopp = 1'b0;
    endtask

    // Frozen read: rewrites the model's byte at addr so the read is side-effect free.
    task automatic peek(input logic mode, input logic [7:0] addr, output logic [7:0] val);
        logic [7:0] e;
        snoopp = 1'b1;
        snoopm = mode;
        snoopa = addr;
        snoopd = m_mem[addr];
        step(e);
        val = snoopq;
    endtask

    task automatic test_reset();
        byte unsigned prog[$];
        logic [7:0]   v;
        prog = {};
        load_program(prog);
        checks++;
        if (snoopq !== 8'h00) begin
            errors++;
            $display("FAIL reset_snoopq: got %02h required 00", snoopq);
        end
        for (int s = 0; s < 4; s++) begin
            peek(1'b1, 8'(s), v);
            checks++;
            if (v !== 8'h00) begin
                errors++;
                $display("FAIL reset_dbg%0d: got %02h required 00", s, v);
            end
        end
    endtask

    task automatic test_plan_program();
        byte unsigned prog[$];
        logic [7:0]   v;
        prog = {8'h68, 8'h15, 8'hA4, 8'hE0, 8'h08, 8'hA4, 8'hE0, 8'h01,
                8'hA4, 8'h01, 8'h8C, 8'h08, 8'h94, 8'h15, 8'h9C, 8'hA8};
        load_program(prog);
        run(21);
        for (int a = 0; a < 32; a++) begin
            peek(1'b0, 8'(a), v);
            checks++;
            if (v !== m_mem[a]) begin
                errors++;
                $display("FAIL plan_mem[%02h]: got %02h required %02h", a, v, m_mem[a]);
            end
        end
        peek(1'b0, 8'h15, v);
        checks++;
        if (v !== 8'h68) begin
            errors++;
            $display("FAIL plan_store15: got %02h required 68", v);
        end
        for (int s = 0; s < 4; s++) begin
            peek(1'b1, 8'(s), v);
            checks++;
            if (v !== dbg_value(s)) begin
                errors++;
                $display("FAIL plan_dbg%0d: got %02h required %02h", s, v, dbg_value(s));
            end
        end
        peek(1'b1, 8'h00, v);
        checks++;
        if (v !== 8'h10) begin
            errors++;
            $display("FAIL plan_pc: got %02h required 10", v);
        end
    endtask

    task automatic test_jz_jmp();
        byte unsigned prog[$];
        logic [7:0]   v;
        prog = {8'h00, 8'h05, 8'hB0, 8'h7F, 8'hA8, 8'h01, 8'h10, 8'hA4, 8'hA8};
        load_program(prog);
        run(15);
        peek(1'b0, 8'h10, v);
        checks++;
        if (v !== 8'h01) begin
            errors++;
            $display("FAIL jz_store: got %02h required 01", v);
        end
        peek(1'b1, 8'h00, v);
        checks++;
        if (v !== 8'h09) begin
            errors++;
            $display("FAIL jz_pc: got %02h required 09", v);
        end
        peek(1'b1, 8'h03, v);
        checks++;
        if (v !== 8'h80) begin
            errors++;
            $display("FAIL jz_status: got %02h required 80", v);
        end
    endtask

    task automatic test_stack_wrap();
        byte unsigned prog[$];
        logic [7:0]   v;
        prog = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'hA8};
        load_program(prog);
        run(12);
        peek(1'b1, 8'h01, v);
        checks++;
        if (v !== 8'h09) begin
            errors++;
            $display("FAIL wrap_tos: got %02h required 09", v);
        end
        peek(1'b1, 8'h02, v);
        checks++;
        if (v !== 8'h08) begin
            errors++;
            $display("FAIL wrap_nos: got %02h required 08", v);
        end
        peek(1'b1, 8'h03, v);
        checks++;
        if (v !== 8'h81) begin
            errors++;
            $display("FAIL wrap_status: got %02h required 81", v);
        end
        prog = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09};
        repeat (9) prog.push_back(8'h84);
        prog.push_back(8'hA8);
        load_program(prog);
        run(22);
        peek(1'b1, 8'h03, v);
        checks++;
        if (v !== 8'h80) begin
            errors++;
            $display("FAIL underflow_status: got %02h required 80", v);
        end
    endtask

    task automatic test_reset_mid_run();
        byte unsigned prog[$];
        logic [7:0]   v, e;
        // Endless loop: mem[0x40] = 5, then JZ 0 with a zero condition.
        prog = {8'h05, 8'h40, 8'hA4, 8'h00, 8'h00, 8'hB0};
        load_program(prog);
        run(10);
        reset  = 1'b1;
        snoopm = 1'b0;
        snoopa = 8'h40;
        step(e);
        checks++;
        if (snoopq !== 8'h00) begin
            errors++;
            $display("FAIL midreset_snoopq: got %02h required 00", snoopq);
        end
        reset = 1'b0;
        peek(1'b0, 8'h40, v);
        checks++;
        if (v !== 8'h05) begin
            errors++;
            $display("FAIL midreset_mem40: got %02h required 05", v);
        end
        for (int s = 0; s < 4; s++) begin
            peek(1'b1, 8'(s), v);
            checks++;
            if (v !== 8'h00) begin
                errors++;
                $display("FAIL midreset_dbg%0d: got %02h required 00", s, v);
            end
        end
    endtask

    task automatic test_snoop_latency();
        logic [7:0] e, old;
        old    = m_mem[8'h33];
        snoopp = 1'b1;
        snoopm = 1'b0;
        snoopa = 8'h33;
        snoopd = 8'h5A;
        step(e);
        checks++;
        if (snoopq !== old) begin
            errors++;
            $display("FAIL latency_same_edge: got %02h required %02h", snoopq, old);
        end
        step(e);
        checks++;
        if (snoopq !== 8'h5A) begin
            errors++;
            $display("FAIL latency_next_edge: got %02h required 5a", snoopq);
        end
    endtask

    task automatic test_random();
        byte unsigned prog[$];
        byte unsigned ops[13];
        logic [7:0]   e;
        int           k;
        ops = '{8'h80, 8'h84, 8'h88, 8'h8C, 8'h90, 8'h94, 8'h98,
                8'h9C, 8'hA0, 8'hA4, 8'hAC, 8'hB0, 8'hC4};
        for (int p = 0; p < 6; p++) begin
            prog = {};
            for (int i = 0; i < 48; i++) begin
                k = int'($urandom_range(0, 15));
                if (k < 13)       prog.push_back(ops[k]);
                else if (k == 13) prog.push_back(8'($urandom_range(0, 127)));
                else if (k == 14) prog.push_back(8'(8'hE0 | $urandom_range(0, 31)));
                else              prog.push_back(($urandom_range(0, 3) == 0) ? 8'hA8 : 8'h7F);
            end
            load_program(prog);
            for (int c = 0; c < 200; c++) begin
                snoopm = 1'($urandom_range(0, 1));
                snoopa = 8'($urandom_range(0, 255));
                snoopd = 8'($urandom_range(0, 255));
                snoopp = ($urandom_range(0, 19) == 0);
                reset  = ($urandom_range(0, 99) == 0);
                step(e);
                checks++;
                if (snoopq !== e) begin
                    errors++;
                    $display("FAIL random_p%0d_c%0d: got %02h required %02h", p, c, snoopq, e);
                end
            end
            reset  = 1'b0;
            snoopp = 1'b0;
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_plan_program();
        test_jz_jmp();
        test_stack_wrap();
        test_reset_mid_run();
        test_snoop_latency();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
